// File: rtl/dma_w_sched_pkg.sv
// dma_w_sched_pkg
// Shared definitions for the DMA write burst scheduler:
//   - default AXI address / len field widths
//   - 4 KB boundary width (AXI bursts may not cross a 4 KB page)
//   - scheduler state encoding
//   - small unsigned min helper used by the burst calculator
package dma_w_sched_pkg;

    localparam int AXI_ADDR_W   = 32;
    localparam int AXI_LEN_W    = 8;
    localparam int BOUNDARY_W   = 12;
    localparam int SCH_STATES_W = 3;

    typedef enum logic [SCH_STATES_W-1:0] {
        SCH_IDLE  = 3'd0,
        SCH_CALC  = 3'd1,
        SCH_ISSUE = 3'd2,
        SCH_WAIT  = 3'd3,
        SCH_DONE  = 3'd4
    } sch_state_e;

    function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc
// Combinational burst sizing: beats = min(remaining, MAX_BURST, beats left
// before the next 4 KB boundary).
// Ports:
//   addr_lo   in  [BOUNDARY_W-1:0]  low address bits of the burst start (beat aligned)
//   remaining in  [XFER_W-1:0]      beats still to be written in the transfer
//   beats     out [XFER_W-1:0]      beats for the next burst (>=1 when remaining>=1)
module dma_burst_calc
    import dma_w_sched_pkg::*;
#(
    parameter int XFER_W    = 16,
    parameter int MAX_BURST = 256,
    parameter int BYTES     = 4
) (
    input  logic [BOUNDARY_W-1:0] addr_lo,
    input  logic [XFER_W-1:0]     remaining,
    output logic [XFER_W-1:0]     beats
);

    localparam int B_LOG2 = $clog2(BYTES);
    localparam logic [BOUNDARY_W:0] PAGE_BYTES = {1'b1, {BOUNDARY_W{1'b0}}};

    // One bit wider than the page offset so a page-aligned address yields a
    // full page (never 0).
    logic [BOUNDARY_W:0] to_4k;
    logic [31:0]         lim;

    always_comb begin
        to_4k = (PAGE_BYTES - {1'b0, addr_lo}) >> B_LOG2;
        lim   = umin(32'(remaining), 32'(MAX_BURST));
        lim   = umin(lim, 32'(to_4k));
        beats = XFER_W'(lim);
    end

endmodule

// File: rtl/dma_w_sched.sv
// dma_w_sched
// Splits one DMA write transfer (start address + beat count) into AXI INCR
// bursts that respect MAX_BURST and the 4 KB boundary, hands them one at a
// time to the write engine and accumulates a sticky burst error flag.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_valid/cfg_ready transfer command handshake
//   cfg_addr            start byte address (sub-beat bits ignored)
//   cfg_words           beats to write (0 = no-op)
//   busy                transfer in progress
//   done                one-cycle completion pulse
//   error               sticky: some burst of the last transfer reported an error
//   eng_valid           burst request to the engine
//   eng_addr, eng_len   burst start address and len (beats-1), held in ISSUE/WAIT
//   eng_ready           engine idle
//   eng_error           engine error flag, sampled when the burst completes
module dma_w_sched
    import dma_w_sched_pkg::*;
#(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int ADDR_W         = AXI_ADDR_W,
    parameter int LEN_W          = AXI_LEN_W,
    parameter int XFER_W         = 16,
    parameter int MAX_BURST      = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [XFER_W-1:0] cfg_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              eng_valid,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [LEN_W-1:0]  eng_len,
    input  logic              eng_ready,
    input  logic              eng_error
);

    localparam int BYTES  = DMA_DATA_WIDTH / 8;
    localparam int B_LOG2 = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    sch_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [XFER_W-1:0] remaining_q, remaining_d;
    logic [XFER_W-1:0] beats_q, beats_d;
    logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic [LEN_W-1:0]  eng_len_q, eng_len_d;
    logic              eng_valid_q, eng_valid_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              seen_ready_q, seen_ready_d;
    logic [XFER_W-1:0] calc_beats;

    dma_burst_calc #(
        .XFER_W    (XFER_W),
        .MAX_BURST (MAX_BURST),
        .BYTES     (BYTES)
    ) u_burst_calc (
        .addr_lo   (cur_addr_q[BOUNDARY_W-1:0]),
        .remaining (remaining_q),
        .beats     (calc_beats)
    );

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        beats_d      = beats_q;
        eng_addr_d   = eng_addr_q;
        eng_len_d    = eng_len_q;
        error_d      = error_q;
        seen_ready_d = seen_ready_q;

        case (state_q)
            SCH_IDLE: begin
                if (cfg_valid) begin
                    cur_addr_d  = cfg_addr & ALIGN_MASK;
                    remaining_d = cfg_words;
                    error_d     = 1'b0;
                    state_d     = (cfg_words == '0) ? SCH_DONE : SCH_CALC;
                end
            end
            SCH_CALC: begin
                eng_addr_d   = cur_addr_q;
                eng_len_d    = LEN_W'(calc_beats - XFER_W'(1));
                beats_d      = calc_beats;
                seen_ready_d = 1'b0;
                state_d      = SCH_ISSUE;
            end
            SCH_ISSUE: begin
                // A low eng_ready only means "accepted" once the engine has been
                // seen idle while we were requesting; before that it is still
                // busy with something else and the request must stay up.
                if (eng_ready) begin
                    seen_ready_d = 1'b1;
                end else if (seen_ready_q) begin
                    state_d = SCH_WAIT;
                end
            end
            SCH_WAIT: begin
                if (eng_ready) begin
                    error_d     = error_q | eng_error;
                    cur_addr_d  = cur_addr_q + (ADDR_W'(beats_q) << B_LOG2);
                    remaining_d = remaining_q - beats_q;
                    state_d     = (remaining_d == '0) ? SCH_DONE : SCH_CALC;
                end
            end
            SCH_DONE: begin
                state_d = SCH_IDLE;
            end
            default: begin
                state_d = SCH_IDLE;
            end
        endcase

        // Outputs are registered, so they follow the next state.
        eng_valid_d = (state_d == SCH_ISSUE);
        cfg_ready_d = (state_d == SCH_IDLE);
        busy_d      = (state_d != SCH_IDLE);
        done_d      = (state_d == SCH_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SCH_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            beats_q      <= '0;
            eng_addr_q   <= '0;
            eng_len_q    <= '0;
            eng_valid_q  <= 1'b0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            seen_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            beats_q      <= beats_d;
            eng_addr_q   <= eng_addr_d;
            eng_len_q    <= eng_len_d;
            eng_valid_q  <= eng_valid_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            seen_ready_q <= seen_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign eng_valid = eng_valid_q;
    assign eng_addr  = eng_addr_q;
    assign eng_len   = eng_len_q;

endmodule
